// File: rtl/mario_power_state_if.sv
// mario_power_state_if
//   Groups the per-cycle event inputs and the power/status outputs of
//   mario_power_state into a single bundle.
//   master : producer of frame_tick, touch_* pulses and fire_btn; consumer of
//            power, invincible, blink, dead and fire_req.
//   slave  : the power-state tracker itself.
interface mario_power_state_if;
    logic       frame_tick;
    logic       touch_flower;
    logic       touch_mushroom;
    logic       touch_enemy;
    logic       fire_btn;
    logic [1:0] power;
    logic       invincible;
    logic       blink;
    logic       dead;
    logic       fire_req;

    modport master (
        output frame_tick, touch_flower, touch_mushroom, touch_enemy, fire_btn,
        input  power, invincible, blink, dead, fire_req
    );

    modport slave (
        input  frame_tick, touch_flower, touch_mushroom, touch_enemy, fire_btn,
        output power, invincible, blink, dead, fire_req
    );
endinterface

// File: rtl/mario_power_state.sv
// mario_power_state
//   Tracks the player's power level (small / big / fire / dead), post-hit
//   invincibility with a blink flag, and a rate-limited fireball request.
//   Ports:
//     sys_clk - only clock
//     RST_N   - synchronous active-low reset
//     bus     - slave side of mario_power_state_if:
//               in : frame_tick, touch_flower, touch_mushroom, touch_enemy, fire_btn
//               out: power[1:0] (0 small, 1 big, 2 fire), invincible, blink,
//                    dead (sticky), fire_req (one-cycle pulse)
module mario_power_state #(
    parameter int INV_FRAMES    = 120,
    parameter int FIRE_COOLDOWN = 15,
    parameter int BLINK_BIT     = 2
) (
    input  logic                 sys_clk,
    input  logic                 RST_N,
    mario_power_state_if.slave   bus
);

    typedef enum logic [1:0] {
        SMALL = 2'd0,
        BIG   = 2'd1,
        FIRE  = 2'd2,
        DEAD  = 2'd3
    } state_e;

    localparam logic [7:0] INV_LOAD  = 8'(INV_FRAMES);
    localparam logic [7:0] COOL_LOAD = 8'(FIRE_COOLDOWN);
    localparam logic [2:0] BLINK_IDX = 3'(BLINK_BIT);

    state_e     state_q, state_d;
    logic [7:0] inv_q, inv_d;
    logic [7:0] cool_q, cool_d;
    logic       btn_prev_q, btn_prev_d;
    logic       fire_req_q, fire_req_d;

    always_comb begin
        state_d    = state_q;
        inv_d      = inv_q;
        cool_d     = cool_q;
        fire_req_d = 1'b0;
        btn_prev_d = bus.fire_btn;

        if (bus.frame_tick && inv_q != '0) begin
            inv_d = inv_q - 8'd1;
        end
        if (bus.frame_tick && cool_q != '0) begin
            cool_d = cool_q - 8'd1;
        end

        // Rising edge of the button while armed; rejected edges are simply lost.
        if (state_q == FIRE && cool_q == '0 && bus.fire_btn && !btn_prev_q) begin
            fire_req_d = 1'b1;
            cool_d     = COOL_LOAD;
        end

        if (state_q != DEAD) begin
            // Flower takes precedence over a simultaneous mushroom, and any
            // pickup swallows an enemy pulse in the same cycle.
            if (bus.touch_flower) begin
                state_d = (state_q == SMALL) ? BIG : FIRE;
            end else if (bus.touch_mushroom) begin
                if (state_q == SMALL) begin
                    state_d = BIG;
                end
            end else if (bus.touch_enemy && inv_q == '0) begin
                unique case (state_q)
                    SMALL: state_d = DEAD;
                    BIG: begin
                        state_d = SMALL;
                        inv_d   = INV_LOAD;
                    end
                    FIRE: begin
                        state_d = BIG;
                        inv_d   = INV_LOAD;
                    end
                    default: state_d = state_q;
                endcase
            end
        end

        // Dropping out of FIRE disarms any pending cooldown.
        if (state_q == FIRE && state_d != FIRE) begin
            cool_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RST_N) begin
            state_q    <= SMALL;
            inv_q      <= '0;
            cool_q     <= '0;
            btn_prev_q <= 1'b0;
            fire_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inv_q      <= inv_d;
            cool_q     <= cool_d;
            btn_prev_q <= btn_prev_d;
            fire_req_q <= fire_req_d;
        end
    end

    assign bus.power      = (state_q == DEAD) ? 2'd0 : 2'(state_q);
    assign bus.invincible = |inv_q;
    assign bus.blink      = (|inv_q) & inv_q[BLINK_IDX];
    assign bus.dead       = (state_q == DEAD);
    assign bus.fire_req   = fire_req_q;

endmodule

// File: tb/tb_mario_power_state.sv
module tb_mario_power_state;

    localparam int INV_FRAMES    = 4;
    localparam int FIRE_COOLDOWN = 3;
    localparam int BLINK_BIT     = 2;

    logic sys_clk = 1'b0;
    logic RST_N   = 1'b0;

    mario_power_state_if bus ();

    mario_power_state #(
        .INV_FRAMES   (INV_FRAMES),
        .FIRE_COOLDOWN(FIRE_COOLDOWN),
        .BLINK_BIT    (BLINK_BIT)
    ) dut (
        .sys_clk(sys_clk),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: power as a number 0..2, frame counters as plain ints.
    int m_power = 0;
    bit m_dead  = 1'b0;
    int m_inv   = 0;
    int m_cool  = 0;
    bit m_prev  = 1'b0;
    bit m_freq  = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit tk, input bit fl, input bit mu,
                              input bit en, input bit bt);
        int  was_power;
        bit  was_fire;
        int  nxt_inv;
        int  nxt_cool;
        if (!r) begin
            m_power = 0; m_dead = 0; m_inv = 0; m_cool = 0; m_prev = 0; m_freq = 0;
            return;
        end
        was_power = m_power;
        was_fire  = !m_dead && m_power == 2;
        nxt_inv   = (tk && m_inv > 0) ? m_inv - 1 : m_inv;
        nxt_cool  = (tk && m_cool > 0) ? m_cool - 1 : m_cool;
        m_freq    = 0;
        if (was_fire && m_cool == 0 && bt && !m_prev) begin
            m_freq   = 1;
            nxt_cool = FIRE_COOLDOWN;
        end
        if (!m_dead) begin
            if (fl) begin
                m_power = (m_power + 1 > 2) ? 2 : m_power + 1;
            end else if (mu) begin
                if (m_power == 0) m_power = 1;
            end else if (en && m_inv == 0) begin
                if (m_power == 0) m_dead = 1;
                else begin
                    m_power = m_power - 1;
                    nxt_inv = INV_FRAMES;
                end
            end
        end
        if (was_power == 2 && (m_power != 2 || m_dead)) nxt_cool = 0;
        m_inv  = nxt_inv;
        m_cool = nxt_cool;
        m_prev = bt;
    endtask

    task automatic cyc(input bit r, input bit tk, input bit fl, input bit mu,
                       input bit en, input bit bt);
        RST_N              = r;
        bus.frame_tick     = tk;
        bus.touch_flower   = fl;
        bus.touch_mushroom = mu;
        bus.touch_enemy    = en;
        bus.fire_btn       = bt;
        @(posedge sys_clk);
        model_step(r, tk, fl, mu, en, bt);
        #1;
        check("power",      int'(bus.power),      m_power);
        check("invincible", int'(bus.invincible), int'(m_inv != 0));
        check("blink",      int'(bus.blink),      int'(m_inv != 0 && ((m_inv >> BLINK_BIT) & 1) == 1));
        check("dead",       int'(bus.dead),       int'(m_dead));
        check("fire_req",   int'(bus.fire_req),   int'(m_freq));
    endtask

    task automatic idle(input int n, input bit tk);
        for (int i = 0; i < n; i++) cyc(1, tk, 0, 0, 0, 0);
    endtask

    initial begin
        bit btn;
        bus.frame_tick = 0; bus.touch_flower = 0; bus.touch_mushroom = 0;
        bus.touch_enemy = 0; bus.fire_btn = 0;

        // Reset state
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_power", int'(bus.power), 0);
        check("rst_fire_req", int'(bus.fire_req), 0);

        // Two flowers, ten cycles apart
        cyc(1, 0, 1, 0, 0, 0);
        check("flower1_power", int'(bus.power), 1);
        idle(9, 0);
        cyc(1, 0, 1, 0, 0, 0);
        check("flower2_power", int'(bus.power), 2);
        check("flower2_dead", int'(bus.dead), 0);

        // Fireball cooldown
        cyc(1, 0, 0, 0, 0, 1);
        check("fire_first", int'(bus.fire_req), 1);
        cyc(1, 0, 0, 0, 0, 0);
        check("fire_single", int'(bus.fire_req), 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        check("fire_cooldown_reject", int'(bus.fire_req), 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        check("fire_after_cooldown", int'(bus.fire_req), 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        check("fire_hold_no_repeat", int'(bus.fire_req), 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);

        // Hit in FIRE with cooldown loaded
        cyc(1, 0, 0, 0, 1, 0);
        check("hit_power", int'(bus.power), 1);
        check("hit_invincible", int'(bus.invincible), 1);
        check("hit_blink", int'(bus.blink), 1);
        cyc(1, 1, 0, 0, 0, 0);
        check("blink_after_tick", int'(bus.blink), 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        check("hit_ignored", int'(bus.power), 1);
        cyc(1, 1, 0, 0, 0, 0);
        check("inv_before_last", int'(bus.invincible), 1);
        cyc(1, 1, 0, 0, 0, 0);
        check("inv_expired", int'(bus.invincible), 0);

        // Back to FIRE: cooldown was cleared on leaving it
        cyc(1, 0, 1, 0, 0, 0);
        check("refire_power", int'(bus.power), 2);
        cyc(1, 0, 0, 0, 0, 1);
        check("refire_immediate", int'(bus.fire_req), 1);
        cyc(1, 0, 0, 0, 0, 0);

        // Flower + enemy in BIG with no invincibility
        cyc(1, 0, 0, 0, 1, 0);
        idle(4, 1);
        check("big_vuln", int'(bus.invincible), 0);
        cyc(1, 0, 1, 0, 1, 0);
        check("pickup_wins_power", int'(bus.power), 2);
        check("pickup_wins_inv", int'(bus.invincible), 0);

        // Mushroom + flower counts as flower
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        check("flower_mush_fire", int'(bus.power), 2);

        // Death and absorption
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        check("death_dead", int'(bus.dead), 1);
        check("death_power", int'(bus.power), 0);
        cyc(1, 0, 1, 0, 0, 1);
        cyc(1, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0, 1);
        check("dead_sticky", int'(bus.dead), 1);
        check("dead_no_fire", int'(bus.fire_req), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("dead_reset", int'(bus.dead), 0);

        // Randomized traffic against the model
        btn = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) btn = ~btn;
            cyc($urandom_range(0, 299) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 14) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 7) == 0,
                btn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
